// File: rtl/adder_mem_pkg.sv
// Shared definitions for the adder memory sum master: FSM state encoding,
// operation codes and default geometry of the on-chip RAM it talks to.
package adder_mem_pkg;

   localparam int DEF_ADDR_W       = 12;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_DEPTH        = 4093;
   localparam int DEF_READ_LATENCY = 1;

   localparam logic OP_SUM  = 1'b0;
   localparam logic OP_FILL = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/adder_mem_sum_master_if.sv
// Bundle of the command/result handshake and the Avalon-MM initiator bus.
// The master modport is the sum master itself; the slave modport is the
// environment (command source plus RAM s1 port).
// Optional macro ADDER_MEM_SUM_MAX_EN adds the result_max signal.
interface adder_mem_sum_master_if
   import adder_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_op;
   logic [ADDR_W-1:0]     cmd_addr;
   logic [ADDR_W:0]       cmd_len;
   logic [DATA_W-1:0]     cmd_data;

   logic [ADDR_W-1:0]     avm_address;
   logic                  avm_chipselect;
   logic                  avm_write;
   logic [DATA_W-1:0]     avm_writedata;
   logic [DATA_W/8-1:0]   avm_byteenable;
   logic                  avm_waitrequest;
   logic [DATA_W-1:0]     avm_readdata;

   logic                  done;
   logic [DATA_W-1:0]     result_sum;
   logic                  result_ovf;
`ifdef ADDER_MEM_SUM_MAX_EN
   logic [DATA_W-1:0]     result_max;
`endif

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data,
      input  avm_waitrequest, avm_readdata,
`ifdef ADDER_MEM_SUM_MAX_EN
      output result_max,
`endif
      output cmd_ready,
      output avm_address, avm_chipselect, avm_write, avm_writedata, avm_byteenable,
      output done, result_sum, result_ovf
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data,
      output avm_waitrequest, avm_readdata,
`ifdef ADDER_MEM_SUM_MAX_EN
      input  result_max,
`endif
      input  cmd_ready,
      input  avm_address, avm_chipselect, avm_write, avm_writedata, avm_byteenable,
      input  done, result_sum, result_ovf
   );

endinterface

// File: rtl/adder_mem_rd_tracker.sv
// Read-return tracker: follows accepted reads through the RAM's fixed read
// latency and folds each returning word into the running sum, the sticky
// carry flag and (with ADDER_MEM_SUM_MAX_EN) the running unsigned maximum.
module adder_mem_rd_tracker
   import adder_mem_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int READ_LATENCY = DEF_READ_LATENCY
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              push,
   input  logic [DATA_W-1:0] rdata,
   output logic              drained,
   output logic [DATA_W-1:0] sum,
   output logic              ovf
`ifdef ADDER_MEM_SUM_MAX_EN
   ,
   output logic [DATA_W-1:0] max_val
`endif
);

   logic [READ_LATENCY-1:0] vld_q;
   logic [READ_LATENCY-1:0] vld_d;
   logic                    data_valid;
   logic [DATA_W:0]         add_w;
   logic [DATA_W-1:0]       sum_q;
   logic                    ovf_q;
`ifdef ADDER_MEM_SUM_MAX_EN
   logic [DATA_W-1:0]       max_q;
`endif

   assign data_valid = vld_q[READ_LATENCY-1];
   assign add_w      = {1'b0, sum_q} + {1'b0, rdata};
   assign sum        = sum_q;
   assign ovf        = ovf_q;
   assign drained    = (vld_d == '0);
`ifdef ADDER_MEM_SUM_MAX_EN
   assign max_val    = max_q;
`endif

   // Next contents of the valid pipeline: shift by one, new read enters at bit 0.
   always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = push;
   end

   // Pipeline register plus accumulator; a new command clears the results.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         sum_q <= '0;
         ovf_q <= 1'b0;
`ifdef ADDER_MEM_SUM_MAX_EN
         max_q <= '0;
`endif
      end else begin
         vld_q <= vld_d;
         if (clear) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
`ifdef ADDER_MEM_SUM_MAX_EN
            max_q <= '0;
`endif
         end else if (data_valid) begin
            sum_q <= add_w[DATA_W-1:0];
            ovf_q <= ovf_q | add_w[DATA_W];
`ifdef ADDER_MEM_SUM_MAX_EN
            if (rdata > max_q) begin
               max_q <= rdata;
            end
`endif
         end
      end
   end

endmodule

// File: rtl/adder_mem_sum_master.sv
// Avalon-MM initiator for the single-port on-chip RAM. Runs one command at a
// time: FILL writes base+index over a word range, SUM reads a range and
// returns the wrapped total plus a sticky carry flag. Addresses wrap from
// DEPTH-1 to 0 and out-of-range start addresses are clamped to 0.
// Optional macro ADDER_MEM_SUM_MAX_EN also reports the largest word read.
module adder_mem_sum_master
   import adder_mem_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int READ_LATENCY = DEF_READ_LATENCY
) (
   input logic                    clk,
   input logic                    reset_n,
   adder_mem_sum_master_if.master bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);
   localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   remain_q;
   logic              op_q;
   logic [DATA_W-1:0] wdata_q;

   logic              cmd_ready_w;
   logic              accept;
   logic              xfer;
   logic              last_xfer;
   logic              rd_push;
   logic              rd_drained;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] next_addr;

   assign cmd_ready_w   = (state_q == IDLE) && reset_n;
   assign accept        = bus.cmd_valid && cmd_ready_w;
   assign xfer          = (state_q == ISSUE) && !bus.avm_waitrequest;
   assign last_xfer     = xfer && (remain_q == LEN_ONE);
   assign rd_push       = xfer && (op_q == OP_SUM);
   assign start_addr    = (bus.cmd_addr > LAST_ADDR) ? '0 : bus.cmd_addr;
   assign next_addr     = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
   assign bus.cmd_ready = cmd_ready_w;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Command latch on accept; address, remaining count and fill value step
   // only on an accepted transfer so a stalled beat stays stable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q   <= '0;
         remain_q <= '0;
         op_q     <= OP_SUM;
         wdata_q  <= '0;
      end else if (accept) begin
         addr_q   <= start_addr;
         remain_q <= bus.cmd_len;
         op_q     <= bus.cmd_op;
         wdata_q  <= bus.cmd_data;
      end else if (xfer) begin
         addr_q   <= next_addr;
         remain_q <= remain_q - LEN_ONE;
         wdata_q  <= wdata_q + DATA_ONE;
      end
   end

   // Next-state and bus outputs; the bus is driven only while issuing.
   always_comb begin
      state_d            = state_q;
      bus.avm_address    = '0;
      bus.avm_chipselect = 1'b0;
      bus.avm_write      = 1'b0;
      bus.avm_writedata  = '0;
      bus.avm_byteenable = '0;
      bus.done           = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (bus.cmd_len == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            bus.avm_address    = addr_q;
            bus.avm_chipselect = 1'b1;
            bus.avm_write      = op_q;
            bus.avm_byteenable = '1;
            if (op_q == OP_FILL) begin
               bus.avm_writedata = wdata_q;
            end
            if (last_xfer) begin
               state_d = (op_q == OP_FILL) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (rd_drained) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   adder_mem_rd_tracker #(
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_tracker (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (accept),
      .push    (rd_push),
      .rdata   (bus.avm_readdata),
      .drained (rd_drained),
      .sum     (bus.result_sum),
      .ovf     (bus.result_ovf)
`ifdef ADDER_MEM_SUM_MAX_EN
      ,
      .max_val (bus.result_max)
`endif
   );

endmodule

// File: tb/tb_adder_mem_sum_master.sv
// Bench for adder_mem_sum_master: directed commands against a RAM model,
// with a command-level reference model predicting every bus transfer,
// completion cycle and result. Honours ADDER_MEM_SUM_MAX_EN when defined.
module tb_adder_mem_sum_master;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4093;
   localparam int RL     = 1;

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] data;
   } xfer_t;

   logic clk = 1'b0;
   logic reset_n;

   adder_mem_sum_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   adder_mem_sum_master #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .DEPTH        (DEPTH),
      .READ_LATENCY (RL)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          accept_cyc = 0;
   int          exp_done_cyc = 0;
   int          last_lat = 0;
   int          xfer_count = 0;
   logic        pending = 1'b0;
   logic [31:0] exp_sum = '0;
   logic        exp_ovf = 1'b0;
   logic [31:0] exp_max = '0;
   xfer_t       exp_q[$];
   int          addr_log[$];
   logic [31:0] model_mem [DEPTH];
   logic [31:0] ram [DEPTH];
   logic [31:0] rd_pipe [RL];

   always @(posedge clk) cyc <= cyc + 1;

   // RAM slave with fixed read latency, no reset.
   always @(posedge clk) begin
      int idx;
      idx = (int'(bus.avm_address) < DEPTH) ? int'(bus.avm_address) : 0;
      if (bus.avm_chipselect && !bus.avm_waitrequest && bus.avm_write)
         ram[idx] <= bus.avm_writedata;
      rd_pipe[0] <= ram[idx];
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.avm_readdata = rd_pipe[RL-1];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison of the bus and the completion against the model.
   always @(negedge clk) begin
      if (reset_n) begin
         checkOutput("cmd_ready", 32'(bus.cmd_ready), pending ? 32'd0 : 32'd1);
         if (bus.avm_chipselect) begin
            checkOutput("byteenable", 32'(bus.avm_byteenable), 32'hF);
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_xfer", 32'(bus.avm_chipselect), 32'd0);
            end else begin
               checkOutput("xfer_addr", 32'(bus.avm_address), 32'(exp_q[0].addr));
               checkOutput("xfer_write", 32'(bus.avm_write), 32'(exp_q[0].wr));
               if (exp_q[0].wr) checkOutput("xfer_wdata", bus.avm_writedata, exp_q[0].data);
               if (!bus.avm_waitrequest) begin
                  addr_log.push_back(int'(bus.avm_address));
                  xfer_count++;
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            checkOutput("byteenable_idle", 32'(bus.avm_byteenable), 32'd0);
         end
         if (bus.done) begin
            if (!pending) begin
               checkOutput("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
               checkOutput("done_cycle", 32'(cyc), 32'(exp_done_cyc));
               last_lat = cyc - accept_cyc;
               checkOutput("result_sum", bus.result_sum, exp_sum);
               checkOutput("result_ovf", 32'(bus.result_ovf), 32'(exp_ovf));
`ifdef ADDER_MEM_SUM_MAX_EN
               checkOutput("result_max", bus.result_max, exp_max);
`endif
               checkOutput("xfers_left", 32'(exp_q.size()), 32'd0);
               pending = 1'b0;
            end
         end
      end
   end

   // Present one command, then predict its transfers and results.
   task automatic issueCommand(input logic op, input int addr, input int len,
                               input logic [31:0] data, input int extra, input int hold);
      int               a;
      int               lat;
      longint unsigned  total;
      logic [31:0]      mx;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = 12'(addr);
      bus.cmd_len   = 13'(len);
      bus.cmd_data  = data;
      @(negedge clk);
      accept_cyc = cyc;
      @(posedge clk); #1;
      a = (addr >= DEPTH) ? 0 : addr;
      total = 0;
      mx = '0;
      for (int i = 0; i < len; i++) begin
         int    ad;
         xfer_t x;
         ad = (a + i) % DEPTH;
         x.wr = op;
         x.addr = 12'(ad);
         if (op) begin
            x.data = data + 32'(i);
            model_mem[ad] = x.data;
         end else begin
            x.data = '0;
            total += 64'(model_mem[ad]);
            if (model_mem[ad] > mx) mx = model_mem[ad];
         end
         exp_q.push_back(x);
      end
      exp_sum = total[31:0];
      exp_ovf = (total > 64'hFFFF_FFFF);
      exp_max = mx;
      lat = (len == 0) ? 1 : (op ? len + 1 : len + RL + 1);
      exp_done_cyc = accept_cyc + lat + extra;
      pending = 1'b1;
      if (hold > 0) begin
         bus.cmd_op   = ~op;
         bus.cmd_addr = 12'h055;
         bus.cmd_len  = 13'd9;
         bus.cmd_data = 32'hDEAD_BEEF;
         repeat (hold) @(posedge clk);
         #1;
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic waitDone();
      int n = 0;
      while (pending && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (pending) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got no done after %0d cycles expected done at cycle %0d", n, exp_done_cyc);
         pending = 1'b0;
         exp_q.delete();
      end
   endtask

   task automatic applyStimulus(input logic op, input int addr, input int len,
                                input logic [31:0] data, input int extra, input int hold);
      issueCommand(op, addr, len, data, extra, hold);
      waitDone();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cnt0;
      int wrap_exp[4];
      wrap_exp = '{4091, 4092, 0, 1};
      for (int i = 0; i < DEPTH; i++) begin
         ram[i] = '0;
         model_mem[i] = '0;
      end
      for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
      reset_n = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op = 1'b0;
      bus.cmd_addr = '0;
      bus.cmd_len = '0;
      bus.cmd_data = '0;
      bus.avm_waitrequest = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      checkOutput("rst_chipselect", 32'(bus.avm_chipselect), 32'd0);
      checkOutput("rst_done", 32'(bus.done), 32'd0);
      checkOutput("rst_sum", bus.result_sum, 32'd0);
      checkOutput("rst_ovf", 32'(bus.result_ovf), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

      $display("[TB] FILL 0x010 len 4, command held valid while busy");
      applyStimulus(1'b1, 16, 4, 32'h100, 0, 2);
      checkOutput("fill_latency", 32'(last_lat), 32'd5);
      for (int i = 0; i < 4; i++) checkOutput("ram_fill", ram[16 + i], 32'h100 + 32'(i));

      $display("[TB] SUM 0x010 len 4");
      applyStimulus(1'b0, 16, 4, 32'h0, 0, 0);
      checkOutput("sum_lit", bus.result_sum, 32'h406);
      checkOutput("sum_ovf_lit", 32'(bus.result_ovf), 32'd0);
      checkOutput("sum_latency", 32'(last_lat), 32'd6);

      $display("[TB] wrap FILL and SUM at 4091");
      addr_log.delete();
      applyStimulus(1'b1, 4091, 4, 32'h1000, 0, 0);
      checkOutput("wrap_count", 32'(addr_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
         checkOutput("wrap_addr", 32'(addr_log[i]), 32'(wrap_exp[i]));
      applyStimulus(1'b0, 4091, 4, 32'h0, 0, 0);
      checkOutput("wrap_sum_lit", bus.result_sum, 32'h4006);

      $display("[TB] overflow SUM");
      applyStimulus(1'b1, 32, 1, 32'hFFFF_FFFF, 0, 0);
      applyStimulus(1'b1, 33, 1, 32'h2, 0, 0);
      applyStimulus(1'b0, 32, 2, 32'h0, 0, 0);
      checkOutput("ovf_sum_lit", bus.result_sum, 32'h1);
      checkOutput("ovf_flag_lit", 32'(bus.result_ovf), 32'd1);
`ifdef ADDER_MEM_SUM_MAX_EN
      checkOutput("ovf_max_lit", bus.result_max, 32'hFFFF_FFFF);
`endif

      $display("[TB] zero-length SUM");
      cnt0 = xfer_count;
      applyStimulus(1'b0, 16, 0, 32'h0, 0, 0);
      checkOutput("len0_latency", 32'(last_lat), 32'd1);
      checkOutput("len0_no_xfer", 32'(xfer_count - cnt0), 32'd0);
      checkOutput("len0_sum", bus.result_sum, 32'd0);
      checkOutput("len0_ovf", 32'(bus.result_ovf), 32'd0);

      $display("[TB] SUM with 3-cycle waitrequest stall");
      cnt0 = xfer_count;
      fork
         applyStimulus(1'b0, 16, 4, 32'h0, 3, 0);
         begin
            repeat (3) @(posedge clk);
            #1 bus.avm_waitrequest = 1'b1;
            repeat (3) @(posedge clk);
            #1 bus.avm_waitrequest = 1'b0;
         end
      join
      checkOutput("stall_sum_lit", bus.result_sum, 32'h406);
      checkOutput("stall_xfers", 32'(xfer_count - cnt0), 32'd4);

      $display("[TB] clamped start address");
      applyStimulus(1'b0, 4095, 2, 32'h0, 0, 0);
      checkOutput("clamp_sum_lit", bus.result_sum, 32'h2005);

      $display("[TB] reset during ISSUE");
      issueCommand(1'b0, 16, 4, 32'h0, 0, 0);
      @(posedge clk); #1;
      reset_n = 1'b0;
      pending = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checkOutput("midrst_chipselect", 32'(bus.avm_chipselect), 32'd0);
      checkOutput("midrst_address", 32'(bus.avm_address), 32'd0);
      checkOutput("midrst_done", 32'(bus.done), 32'd0);
      checkOutput("midrst_sum", bus.result_sum, 32'd0);
      checkOutput("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (4) @(posedge clk);
      applyStimulus(1'b1, 48, 3, 32'h7, 0, 0);
      checkOutput("post_rst_fill_latency", 32'(last_lat), 32'd4);
      applyStimulus(1'b0, 48, 3, 32'h0, 0, 0);
      checkOutput("post_rst_sum_lit", bus.result_sum, 32'h18);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_mem_sum_master.md
Name: adder_mem_sum_master

Overview:
- Avalon-MM initiator that drives the single-port on-chip RAM slave (32-bit data, word address, byteenable, fixed read latency, no waitrequest on that slave).
- Accepts one command at a time. Two operations:
  - FILL: writes an incrementing pattern to a range of words.
  - SUM: reads a range of words, accumulates them, and returns the sum.
- Sits between the adder control logic / CPU-side register block and the RAM's s1 port, so self-test and array summation run without the Nios core.

Parameters:
- ADDR_W, 12, word-address width of avm_address.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 4093, number of valid words; addresses wrap from DEPTH-1 to 0.
- READ_LATENCY, 1, cycles from an accepted read to valid avm_readdata (range 1..3).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = SUM, 1 = FILL.
- cmd_addr  in  ADDR_W  start word address; must be < DEPTH.
- cmd_len  in  ADDR_W+1  word count; 0 is legal.
- cmd_data  in  DATA_W  FILL base value.
- avm_address  out  ADDR_W  word address.
- avm_chipselect  out  1  transfer select.
- avm_write  out  1  1 = write, 0 = read (when chipselect is high).
- avm_writedata  out  DATA_W  write data.
- avm_byteenable  out  DATA_W/8  all ones during a transfer, else 0.
- avm_waitrequest  in  1  stall; tie to 0 for the on-chip RAM.
- avm_readdata  in  DATA_W  read data.
- done  out  1  one-cycle completion pulse.
- result_sum  out  DATA_W  SUM result, modulo 2^DATA_W; holds until the next accepted command.
- result_ovf  out  1  set if any carry out of DATA_W occurred during the SUM.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state = IDLE.
  - All outputs 0, except cmd_ready = 1 once reset deasserts.
  - Read-valid pipeline cleared; any in-flight command is discarded with no done pulse.
- State machine: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - cmd_valid & cmd_ready accepts the command.
  - Latch addr, len, op and data; clear result_sum and result_ovf.
  - cmd_len = 0: go to DONE.
  - Otherwise: go to ISSUE.
- ISSUE:
  - Each cycle: chipselect = 1; byteenable = all ones; avm_write = op.
  - FILL writedata = cmd_data + index, where index counts 0..len-1, modulo 2^DATA_W.
  - A transfer is accepted when chipselect & !waitrequest. On acceptance, advance address and decrement the remaining count.
  - While waitrequest is high, hold address, write, writedata and byteenable stable.
  - Address wrap: DEPTH-1 -> 0. It never presents an address >= DEPTH.
  - After the last accepted transfer:
    - FILL goes to DONE.
    - SUM goes to DRAIN.
- Read tracking:
  - A READ_LATENCY-deep shift register of valid bits, set on each accepted read.
  - When the output bit is set, avm_readdata is added into result_sum; a carry sets result_ovf (sticky).
- DRAIN:
  - chipselect = 0.
  - Wait until the valid pipeline is empty, then go to DONE.
- DONE:
  - done = 1 for exactly one cycle; then go to IDLE.
  - result_sum and result_ovf are final in the done cycle.
- Latency with no stalls, from the accept cycle:
  - SUM: done asserts len + READ_LATENCY + 1 cycles later.
  - FILL: done asserts len + 1 cycles later.
  - len = 0: done asserts the next cycle.
- cmd_valid while busy is ignored (cmd_ready = 0); no queueing.
- An out-of-range cmd_addr (>= DEPTH) is clamped to 0.

Optional Feature:
- Macro: ADDER_MEM_SUM_MAX_EN.
- Defined:
  - Adds output result_max (DATA_W): the unsigned maximum of words read during SUM.
  - Cleared on accept and on reset; updated in the same cycle as the accumulation; 0 when len = 0.
  - FILL leaves it at 0.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Package adder_mem_pkg holds:
  - state enum (IDLE, ISSUE, DRAIN, DONE);
  - OP_SUM / OP_FILL constants;
  - default ADDR_W, DATA_W, DEPTH.
- One sub-module: adder_mem_rd_tracker. It contains the valid shift register plus the accumulator, overflow flag and optional max, and reports when it is empty.

Test Plan:
- FILL addr = 0x010, len = 4, data = 0x100 -> writes 0x100..0x103 to 0x010..0x013; done asserts 5 cycles after accept.
- SUM of that range -> result_sum = 0x406, result_ovf = 0; done asserts 6 cycles after accept (READ_LATENCY = 1).
- Wrap: FILL addr = 4091, len = 4 -> addresses 4091, 4092, 0, 1; then SUM the same range returns the correct total.
- Overflow: SUM over words 0xFFFFFFFF and 0x00000002 -> result_sum = 0x1, result_ovf = 1; with ADDER_MEM_SUM_MAX_EN, result_max = 0xFFFFFFFF.
- len = 0 -> done pulse in the cycle after accept; no chipselect asserted; result_sum = 0.
- Waitrequest high for 3 cycles mid-SUM holds address stable with no double count. Reset pulsed mid-ISSUE -> all outputs 0 and no done pulse; the next command completes normally.
